uart_tx_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one UART_Module transmitter among NUM_REQ byte requesters.
- Drives tx_data, tx_start and tx_complete_del_flag.
- Performs the flag-clear handshake on the receive side, presenting received bytes as a one-cycle strobe.
- Runs on the system clk and synchronises all UART status flags, which originate in the tx_clk/rx_clk domains.

---
 rtl/uart_ctrl_pkg.sv | 22 ++
 rtl/flag_sync.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared types for the UART transmit arbiter / receive sequencer.
//   tx_state_t  : transmit sequencer states
//   rx_state_t  : receive flag-clear handshake states
//   SYNC_STAGES : depth of the status-flag synchronisers
package uart_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_DONE,
        CLEAR,
        ABORT
    } tx_state_t;

    typedef enum logic {
        R_IDLE,
        R_CLEAR
    } rx_state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/flag_sync.sv
// Multi-flop synchroniser for a single level signal from a foreign clock domain.
//   clk     : destination clock
//   reset_n : asynchronous active-low reset, clears the chain
//   d       : asynchronous input level
//   q       : synchronised level, SYNC_STAGES cycles of latency
module flag_sync
    import uart_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte requesters,
// plus the receive-side flag-clear handshake.
//   clk, reset_n          : system clock, async active-low reset
//   req_valid/req_data    : per-requester byte requests (held until req_ack)
//   req_ack, req_err      : completion pulse per requester, err on start timeout
//   tx_data, tx_start     : byte and start strobe to the UART transmitter
//   tx_complete_del_flag  : clears the UART tx_complete_flag (four-phase)
//   tx_busy, tx_complete_flag : UART transmit status (foreign clock domain)
//   rx_data, rx_complete_flag : UART receive byte and done flag (foreign domain)
//   rx_complete_del_flag  : clears the UART rx_complete_flag (four-phase)
//   rx_byte, rx_valid     : captured received byte and its one-cycle strobe
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic                 req_err,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    output logic                 tx_complete_del_flag,
    input  logic                 tx_busy,
    input  logic                 tx_complete_flag,
    input  logic [7:0]           rx_data,
    input  logic                 rx_complete_flag,
    output logic                 rx_complete_del_flag,
    output logic [7:0]           rx_byte,
    output logic                 rx_valid
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int TW = $clog2(START_TIMEOUT + 1);

    // ---------------- status synchronisers ----------------
    logic tx_busy_s, tx_complete_flag_s, rx_complete_flag_s;

    flag_sync u_sync_busy (.clk(clk), .reset_n(reset_n), .d(tx_busy),          .q(tx_busy_s));
    flag_sync u_sync_txcf (.clk(clk), .reset_n(reset_n), .d(tx_complete_flag), .q(tx_complete_flag_s));
    flag_sync u_sync_rxcf (.clk(clk), .reset_n(reset_n), .d(rx_complete_flag), .q(rx_complete_flag_s));

    // ---------------- round-robin picker ----------------
    logic [PW-1:0] rr_ptr, grant, pick, ptr_inc;
    logic          pick_vld;

    // Scan from the highest offset down so the nearest valid requester
    // after rr_ptr is the last (winning) assignment.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
                pick     = PW'((int'(rr_ptr) + i) % NUM_REQ);
                pick_vld = 1'b1;
            end
        end
    end

    assign ptr_inc = (grant == PW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

    // ---------------- TX sequencer ----------------
    tx_state_t     state, state_nxt;
    logic [TW-1:0] tmo_cnt;
    logic          stale;      // current CLEAR services a leftover flag, not a job
    logic          set_stale, ld_grant, adv;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            grant   <= '0;
            tx_data <= '0;
            tmo_cnt <= '0;
            stale   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ld_grant) begin
                grant   <= pick;
                tx_data <= req_data[8*int'(pick) +: 8];
            end
            if (adv) rr_ptr <= ptr_inc;
            if (state == IDLE) stale <= set_stale;
            // Counts cycles spent in START; saturates, cleared elsewhere.
            if (state == START) begin
                if (tmo_cnt != TW'(START_TIMEOUT)) tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nxt            = state;
        tx_start             = 1'b0;
        tx_complete_del_flag = 1'b0;
        req_ack              = '0;
        req_err              = 1'b0;
        ld_grant             = 1'b0;
        adv                  = 1'b0;
        set_stale            = 1'b0;
        case (state)
            IDLE: begin
                // A leftover done flag must be cleared before a new start,
                // otherwise it would be mistaken for the new job's completion.
                if (tx_complete_flag_s) begin
                    set_stale = 1'b1;
                    state_nxt = CLEAR;
                end else if (pick_vld) begin
                    ld_grant  = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                tx_start = 1'b1;
                // A very short frame may finish before busy is ever seen.
                if (tx_busy_s || tx_complete_flag_s) begin
                    state_nxt = WAIT_DONE;
                end else if (tmo_cnt == TW'(START_TIMEOUT - 1)) begin
                    state_nxt = ABORT;
                end
            end
            WAIT_DONE: begin
                if (tx_complete_flag_s) state_nxt = CLEAR;
            end
            CLEAR: begin
                if (tx_complete_flag_s) begin
                    tx_complete_del_flag = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    if (!stale) begin
                        req_ack[grant] = 1'b1;
                        adv            = 1'b1;
                    end
                end
            end
            ABORT: begin
                req_ack[grant] = 1'b1;
                req_err        = 1'b1;
                adv            = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- RX handshake ----------------
    rx_state_t rx_state, rx_state_nxt;
    logic      rx_cap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state <= R_IDLE;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_valid <= rx_cap;
            if (rx_cap) rx_byte <= rx_data;
        end
    end

    always_comb begin
        rx_state_nxt         = rx_state;
        rx_complete_del_flag = 1'b0;
        rx_cap               = 1'b0;
        case (rx_state)
            R_IDLE: begin
                if (rx_complete_flag_s) begin
                    rx_cap       = 1'b1;
                    rx_state_nxt = R_CLEAR;
                end
            end
            R_CLEAR: begin
                if (rx_complete_flag_s) rx_complete_del_flag = 1'b1;
                else                    rx_state_nxt         = R_IDLE;
            end
            default: rx_state_nxt = R_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a behavioural UART responds to tx_start,
// requesters drop req_valid on their ack, and a monitor logs acks, starts and
// start-pulse lengths for comparison against hand-computed expectations.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ack;
    logic           req_err;
    logic [7:0]     tx_data;
    logic           tx_start, tx_complete_del_flag;
    logic           tx_busy, tx_complete_flag;
    logic [7:0]     rx_data;
    logic           rx_complete_flag, rx_complete_del_flag;
    logic [7:0]     rx_byte;
    logic           rx_valid;

    // second instance with a short start timeout and a dead UART
    logic [N-1:0]   req_valid_t;
    logic [8*N-1:0] req_data_t;
    logic [N-1:0]   req_ack_t;
    logic           req_err_t, tx_start_t, tx_del_t, rx_del_t, rx_valid_t;
    logic [7:0]     tx_data_t, rx_byte_t;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(1023)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_data(req_data),
        .req_ack(req_ack), .req_err(req_err),
        .tx_data(tx_data), .tx_start(tx_start),
        .tx_complete_del_flag(tx_complete_del_flag),
        .tx_busy(tx_busy), .tx_complete_flag(tx_complete_flag),
        .rx_data(rx_data), .rx_complete_flag(rx_complete_flag),
        .rx_complete_del_flag(rx_complete_del_flag),
        .rx_byte(rx_byte), .rx_valid(rx_valid)
    );

    uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(15)) dut_t (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid_t), .req_data(req_data_t),
        .req_ack(req_ack_t), .req_err(req_err_t),
        .tx_data(tx_data_t), .tx_start(tx_start_t),
        .tx_complete_del_flag(tx_del_t),
        .tx_busy(1'b0), .tx_complete_flag(1'b0),
        .rx_data(8'h00), .rx_complete_flag(1'b0),
        .rx_complete_del_flag(rx_del_t),
        .rx_byte(rx_byte_t), .rx_valid(rx_valid_t)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // ---------------- monitor (samples on negedge) ----------------
    int         cyc = 0, ack_cyc = -100, cur_len = 0, t_cur = 0;
    int         ack_q[$], err_q[$], start_q[$], gap_q[$], len_q[$];
    int         t_ack_q[$], t_err_q[$], t_len_q[$];
    int         rx_cnt = 0, rx_del_cnt = 0, del_cnt = 0, orphan = 0, t_orphan = 0;
    logic [7:0] rx_last = '0;
    logic       start_d = 1'b0, t_start_d = 1'b0;
    logic [N-1:0] ack_seen = '0, t_ack_seen = '0;

    initial forever begin
        @(negedge clk);
        cyc++;
        ack_seen   = req_ack;
        t_ack_seen = req_ack_t;
        if (reset_n) begin
            if (|req_ack) begin
                ack_q.push_back(oh2i(req_ack));
                err_q.push_back(int'(req_err));
                ack_cyc = cyc;
            end else if (req_err) orphan++;
            if (tx_start && !start_d) begin
                start_q.push_back(int'(tx_data));
                gap_q.push_back(cyc - ack_cyc);
                cur_len = 0;
            end
            if (tx_start) cur_len++;
            if (!tx_start && start_d) len_q.push_back(cur_len);
            start_d = tx_start;
            if (rx_valid) begin rx_cnt++; rx_last = rx_byte; end
            if (rx_complete_del_flag) rx_del_cnt++;
            if (tx_complete_del_flag) del_cnt++;

            if (|req_ack_t) begin
                t_ack_q.push_back(oh2i(req_ack_t));
                t_err_q.push_back(int'(req_err_t));
            end else if (req_err_t) t_orphan++;
            if (tx_start_t && !t_start_d) t_cur = 0;
            if (tx_start_t) t_cur++;
            if (!tx_start_t && t_start_d) t_len_q.push_back(t_cur);
            t_start_d = tx_start_t;
        end else begin
            start_d   = 1'b0;
            t_start_d = 1'b0;
        end
    end

    // ---------------- UART model + requester drop (posedge + 3) ----------------
    int   busy_dly = 3, done_dly = 10, m_cnt = 0;
    logic m_active = 1'b0, hold = 1'b0;

    initial forever begin
        @(posedge clk);
        #3;
        if (!reset_n) begin
            tx_busy          = 1'b0;
            tx_complete_flag = 1'b0;
            m_active         = 1'b0;
        end else begin
            if (tx_complete_del_flag) tx_complete_flag = 1'b0;
            if (rx_complete_del_flag) rx_complete_flag = 1'b0;
            if (!m_active && tx_start) begin m_active = 1'b1; m_cnt = 0; end
            if (m_active) begin
                m_cnt++;
                if (m_cnt == busy_dly) tx_busy = 1'b1;
                if (m_cnt == done_dly) begin
                    tx_busy          = 1'b0;
                    tx_complete_flag = 1'b1;
                    m_active         = 1'b0;
                end
            end
            if (!hold) begin
                req_valid   = req_valid & ~ack_seen;
                req_valid_t = req_valid_t & ~t_ack_seen;
            end
        end
    end

    task automatic clr_logs();
        ack_q.delete(); err_q.delete(); start_q.delete(); gap_q.delete(); len_q.delete();
        ack_cyc = -100; rx_cnt = 0; rx_del_cnt = 0; del_cnt = 0; orphan = 0;
    endtask

    task automatic wait_acks(input int n, input int budget);
        int k = 0;
        while (ack_q.size() < n && k < budget) begin @(negedge clk); k++; end
    endtask

    task automatic wait_len(input int n, input int budget);
        int k = 0;
        while (len_q.size() < n && k < budget) begin @(negedge clk); k++; end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        idle(1);
        reset_n = 1'b0;
        idle(3);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int k;
        req_valid = '0; req_data = '0; req_valid_t = '0; req_data_t = 32'h44332211;
        rx_data = '0; rx_complete_flag = 1'b0; tx_busy = 1'b0; tx_complete_flag = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_req_ack", req_ack, 0);
        chk("rst_tx_del", tx_complete_del_flag, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_del", rx_complete_del_flag, 0);
        idle(1);
        reset_n = 1'b1;

        // 1: single request, slow UART
        clr_logs(); busy_dly = 20; done_dly = 200;
        idle(2);
        req_data[23:16] = 8'hA5;
        req_valid = 4'b0100;
        wait_acks(1, 400);
        chk("t1_acks", ack_q.size(), 1);
        chk("t1_idx", qget(ack_q, 0), 2);
        chk("t1_err", qget(err_q, 0), 0);
        chk("t1_data", qget(start_q, 0), 'hA5);
        chk("t1_start_len", qget(len_q, 0), 22);
        chk("t1_del_seen", del_cnt > 0, 1);
        @(negedge clk);
        chk("t1_del_off", tx_complete_del_flag, 0);
        chk("t1_flag_clr", tx_complete_flag, 0);

        // 2: all four requesters from reset, then again
        do_reset();
        clr_logs(); busy_dly = 3; done_dly = 10;
        req_data = 32'h13121110;
        req_valid = 4'hF;
        wait_acks(4, 400);
        chk("t2_acks", ack_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_idx%0d", i), qget(ack_q, i), i);
            chk($sformatf("t2_data%0d", i), qget(start_q, i), 'h10 + i);
        end
        chk("t2_turnaround", qget(gap_q, 1), 2);
        idle(3);
        clr_logs();
        req_valid = 4'hF;
        wait_acks(4, 400);
        for (int i = 0; i < 4; i++) chk($sformatf("t2b_idx%0d", i), qget(ack_q, i), i);

        // 3: fairness with requesters 1 and 3 held
        idle(3);
        clr_logs(); hold = 1'b1;
        req_valid = 4'b1010;
        wait_acks(4, 400);
        idle(1);
        req_valid = '0;
        hold = 1'b0;
        chk("t3_g0", qget(ack_q, 0), 1);
        chk("t3_g1", qget(ack_q, 1), 3);
        chk("t3_g2", qget(ack_q, 2), 1);
        chk("t3_g3", qget(ack_q, 3), 3);

        // stale done flag in IDLE is cleared before re-arbitrating
        idle(3);
        clr_logs();
        tx_complete_flag = 1'b1;
        idle(2);
        req_valid = 4'b0010;
        wait_acks(1, 200);
        chk("stale_acks", ack_q.size(), 1);
        chk("stale_idx", qget(ack_q, 0), 1);
        chk("stale_starts", start_q.size(), 1);
        chk("stale_data", qget(start_q, 0), 'h11);

        // 4: start timeout on the short-timeout instance
        idle(2);
        req_valid_t = 4'b0001;
        k = 0;
        while (t_ack_q.size() < 1 && k < 100) begin @(negedge clk); k++; end
        chk("t4_acks", t_ack_q.size(), 1);
        chk("t4_idx", qget(t_ack_q, 0), 0);
        chk("t4_err", qget(t_err_q, 0), 1);
        chk("t4_start_len", qget(t_len_q, 0), 15);
        idle(3);
        req_valid_t = 4'b0011;
        k = 0;
        while (t_ack_q.size() < 2 && k < 100) begin @(negedge clk); k++; end
        req_valid_t = '0;
        chk("t4_next_idx", qget(t_ack_q, 1), 1);
        chk("t4_next_err", qget(t_err_q, 1), 1);
        chk("t4_orphan_err", t_orphan, 0);

        // 5: receive during WAIT_DONE
        idle(3);
        clr_logs(); busy_dly = 3; done_dly = 40;
        req_valid = 4'b0001;
        wait_len(1, 100);
        rx_data = 8'h3C;
        rx_complete_flag = 1'b1;
        wait_acks(1, 200);
        idle(10);
        chk("t5_rx_cnt", rx_cnt, 1);
        chk("t5_rx_byte", rx_last, 'h3C);
        chk("t5_rx_del_seen", rx_del_cnt > 0, 1);
        chk("t5_rx_flag_clr", rx_complete_flag, 0);
        chk("t5_rx_del_off", rx_complete_del_flag, 0);
        chk("t5_tx_idx", qget(ack_q, 0), 0);
        chk("t5_tx_err", qget(err_q, 0), 0);

        // 6: reset during WAIT_DONE, requester still valid afterwards
        idle(3);
        clr_logs();
        req_data[23:16] = 8'h5A;
        req_valid = 4'b0100;
        wait_len(1, 100);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("t6_tx_start", tx_start, 0);
        chk("t6_tx_data", tx_data, 0);
        chk("t6_req_ack", req_ack, 0);
        chk("t6_req_err", req_err, 0);
        chk("t6_tx_del", tx_complete_del_flag, 0);
        idle(3);
        reset_n = 1'b1;
        wait_acks(1, 300);
        chk("t6_acks", ack_q.size(), 1);
        chk("t6_idx", qget(ack_q, 0), 2);
        chk("t6_restarts", start_q.size(), 2);
        chk("t6_data", qget(start_q, 1), 'h5A);
        chk("orphan_err", orphan, 0);

        idle(5);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
